// File: rtl/rx_frame_filter_ctrl_if.sv
// RX byte stream with parser field flags, plus the per-frame decision outputs
// returned by the frame filter.
interface rx_frame_filter_ctrl_if;
  logic [7:0]  rx_data_i;
  logic        rx_data_valid_i;
  logic        is_preamble_or_sfd_i;
  logic        is_dst_mac_i;
  logic        is_src_mac_i;
  logic        is_ether_type_i;
  logic        is_payload_or_crc_i;
  logic        invalid_frame_i;
  logic        frame_start_o;
  logic        frame_accept_o;
  logic        frame_drop_o;
  logic [1:0]  drop_reason_o;
  logic [15:0] ether_type_o;
  logic [10:0] frame_len_o;

  modport master (
    output rx_data_i, rx_data_valid_i, is_preamble_or_sfd_i, is_dst_mac_i,
           is_src_mac_i, is_ether_type_i, is_payload_or_crc_i, invalid_frame_i,
    input  frame_start_o, frame_accept_o, frame_drop_o, drop_reason_o,
           ether_type_o, frame_len_o
  );

  modport slave (
    input  rx_data_i, rx_data_valid_i, is_preamble_or_sfd_i, is_dst_mac_i,
           is_src_mac_i, is_ether_type_i, is_payload_or_crc_i, invalid_frame_i,
    output frame_start_o, frame_accept_o, frame_drop_o, drop_reason_o,
           ether_type_o, frame_len_o
  );
endinterface

// File: rtl/rx_frame_filter_ctrl.sv
// Per-frame accept/drop controller: tracks frame phases from parser flags, matches
// the destination MAC, checks length/errors and issues one registered decision per frame.
module rx_frame_filter_ctrl #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  rx_frame_filter_ctrl_if.slave rx,
  input  logic [47:0]           station_mac_i,
  input  logic                  promisc_i,
  input  logic                  bcast_en_i,
  input  logic                  mcast_en_i,
  output logic [CNT_W-1:0]      accept_cnt_o,
  output logic [CNT_W-1:0]      drop_cnt_o
);
  typedef enum logic [2:0] {IDLE, PRE, DST, SRC, ETYPE, PAYLOAD, DISCARD} state_t;

  localparam logic [10:0] MIN_L  = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L  = 11'(MAX_LEN);
  localparam logic [1:0]  R_ADDR = 2'd0;
  localparam logic [1:0]  R_ERR  = 2'd1;
  localparam logic [1:0]  R_RUNT = 2'd2;
  localparam logic [1:0]  R_OVER = 2'd3;

  state_t           state_reg, state_next;
  logic [2:0]       idx_reg, idx_next;
  logic [10:0]      len_reg, len_next, len_inc;
  logic             err_reg, err_next;
  logic             uc_reg, uc_next, bc_reg, bc_next, mc_reg, mc_next;
  logic             first_reg;
  logic [15:0]      etype_reg, etype_next;
  logic             start_reg, start_next;
  logic             accept_reg, accept_next, drop_reg, drop_next;
  logic [1:0]       reason_reg, reason_next;
  logic [10:0]      flen_reg, flen_next;
  logic [CNT_W-1:0] acnt_reg, dcnt_reg;
  logic [7:0]       station_octet [8];
  logic             valid, byte_is_uc, byte_is_bc, end_err, addr_ok;
  logic             abort_now, bad_flag, eof_now;

  // Octet 0 is the first on the wire; indices 6/7 are never compared against.
  for (genvar gi = 0; gi < 8; gi++) begin : g_octet
    if (gi < 6) begin : g_real
      assign station_octet[gi] = station_mac_i[47-8*gi -: 8];
    end else begin : g_pad
      assign station_octet[gi] = 8'h00;
    end
  end

  assign valid      = rx.rx_data_valid_i;
  assign len_inc    = (len_reg == 11'h7FF) ? len_reg : len_reg + 11'd1;
  assign byte_is_uc = (rx.rx_data_i == station_octet[idx_reg]);
  assign byte_is_bc = (rx.rx_data_i == 8'hFF);
  assign end_err    = err_reg | rx.invalid_frame_i;
  assign addr_ok    = promisc_i | uc_reg | (bc_reg & bcast_en_i) | (mc_reg & ~bc_reg & mcast_en_i);

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    len_next    = len_reg;
    err_next    = (state_reg == IDLE) ? 1'b0 : end_err;
    uc_next     = uc_reg;
    bc_next     = bc_reg;
    mc_next     = mc_reg;
    etype_next  = etype_reg;
    start_next  = 1'b0;
    accept_next = 1'b0;
    drop_next   = 1'b0;
    reason_next = reason_reg;
    flen_next   = flen_reg;
    abort_now   = 1'b0;
    bad_flag    = 1'b0;
    eof_now     = 1'b0;

    case (state_reg)
      IDLE: begin
        idx_next = 3'd0;
        // A byte seen straight out of reset belongs to a frame we joined late.
        if (valid && first_reg)                    state_next = DISCARD;
        else if (valid && rx.is_preamble_or_sfd_i) state_next = PRE;
      end
      PRE: begin
        if (!valid) begin
          state_next = IDLE;
        end else if (rx.is_dst_mac_i) begin
          state_next = DST;
          start_next = 1'b1;
          idx_next   = 3'd1;
          len_next   = 11'd1;
          uc_next    = byte_is_uc;
          bc_next    = byte_is_bc;
          mc_next    = rx.rx_data_i[0];
        end else if (!rx.is_preamble_or_sfd_i) begin
          state_next = DISCARD;
        end
      end
      DST: begin
        if (!valid) abort_now = 1'b1;
        else if (rx.is_dst_mac_i && idx_reg < 3'd6) begin
          uc_next  = uc_reg & byte_is_uc;
          bc_next  = bc_reg & byte_is_bc;
          idx_next = idx_reg + 3'd1;
          len_next = len_inc;
        end else if (rx.is_src_mac_i && idx_reg == 3'd6) begin
          state_next = SRC;
          idx_next   = 3'd1;
          len_next   = len_inc;
        end else bad_flag = 1'b1;
      end
      SRC: begin
        if (!valid) abort_now = 1'b1;
        else if (rx.is_src_mac_i && idx_reg < 3'd6) begin
          idx_next = idx_reg + 3'd1;
          len_next = len_inc;
        end else if (rx.is_ether_type_i && idx_reg == 3'd6) begin
          state_next        = ETYPE;
          idx_next          = 3'd1;
          len_next          = len_inc;
          etype_next[15:8]  = rx.rx_data_i;
        end else bad_flag = 1'b1;
      end
      ETYPE: begin
        if (!valid) abort_now = 1'b1;
        else if (rx.is_ether_type_i && idx_reg == 3'd1) begin
          etype_next[7:0] = rx.rx_data_i;
          idx_next        = 3'd2;
          len_next        = len_inc;
        end else if (rx.is_payload_or_crc_i && idx_reg == 3'd2) begin
          state_next = PAYLOAD;
          len_next   = len_inc;
        end else bad_flag = 1'b1;
      end
      PAYLOAD: begin
        if (!valid)                        eof_now  = 1'b1;
        else if (rx.is_payload_or_crc_i)   len_next = len_inc;
        else                               bad_flag = 1'b1;
      end
      DISCARD: begin
        if (!valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (abort_now) begin
      drop_next   = 1'b1;
      reason_next = R_RUNT;
      flen_next   = len_reg;
      state_next  = IDLE;
    end
    if (bad_flag) begin
      drop_next   = 1'b1;
      reason_next = R_ERR;
      flen_next   = len_reg;
      state_next  = DISCARD;
    end
    // Priority: error, oversize, runt, address mismatch.
    if (eof_now) begin
      flen_next  = len_reg;
      state_next = IDLE;
      if (end_err)              begin drop_next = 1'b1; reason_next = R_ERR;  end
      else if (len_reg > MAX_L) begin drop_next = 1'b1; reason_next = R_OVER; end
      else if (len_reg < MIN_L) begin drop_next = 1'b1; reason_next = R_RUNT; end
      else if (!addr_ok)        begin drop_next = 1'b1; reason_next = R_ADDR; end
      else                      accept_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      len_reg    <= '0;
      err_reg    <= 1'b0;
      uc_reg     <= 1'b0;
      bc_reg     <= 1'b0;
      mc_reg     <= 1'b0;
      first_reg  <= 1'b1;
      etype_reg  <= '0;
      start_reg  <= 1'b0;
      accept_reg <= 1'b0;
      drop_reg   <= 1'b0;
      reason_reg <= '0;
      flen_reg   <= '0;
      acnt_reg   <= '0;
      dcnt_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      len_reg    <= len_next;
      err_reg    <= err_next;
      uc_reg     <= uc_next;
      bc_reg     <= bc_next;
      mc_reg     <= mc_next;
      first_reg  <= 1'b0;
      etype_reg  <= etype_next;
      start_reg  <= start_next;
      accept_reg <= accept_next;
      drop_reg   <= drop_next;
      reason_reg <= reason_next;
      flen_reg   <= flen_next;
      if (accept_next && acnt_reg != '1) acnt_reg <= acnt_reg + CNT_W'(1);
      if (drop_next && dcnt_reg != '1)   dcnt_reg <= dcnt_reg + CNT_W'(1);
    end
  end

  assign rx.frame_start_o  = start_reg;
  assign rx.frame_accept_o = accept_reg;
  assign rx.frame_drop_o   = drop_reg;
  assign rx.drop_reason_o  = reason_reg;
  assign rx.ether_type_o   = etype_reg;
  assign rx.frame_len_o    = flen_reg;
  assign accept_cnt_o      = acnt_reg;
  assign drop_cnt_o        = dcnt_reg;
endmodule

// File: tb/tb_rx_frame_filter_ctrl.sv
// Bench for rx_frame_filter_ctrl: directed scenarios plus randomized frames checked
// against a frame-level reference model of the accept/drop rules.
module tb_rx_frame_filter_ctrl;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [47:0]      sta = '0;
  logic             promisc = 1'b0, bc_en = 1'b0, mc_en = 1'b0;
  logic [CNT_W-1:0] acnt, dcnt;

  int vectors = 0, miscompares = 0;
  int acc_exp = 0, drop_exp = 0;
  int start_tally = 0, acc_tally = 0, drop_tally = 0;
  bit both_seen = 1'b0;

  // Observations captured by send_frame in the cycle after the end cycle.
  bit          o_start, o_acc, o_drop, o_extra;
  logic [1:0]  o_reason;
  logic [10:0] o_len;
  logic [15:0] o_et;
  logic [CNT_W-1:0] o_acnt, o_dcnt;

  rx_frame_filter_ctrl_if bus();

  rx_frame_filter_ctrl #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rx(bus), .station_mac_i(sta), .promisc_i(promisc),
    .bcast_en_i(bc_en), .mcast_en_i(mc_en), .accept_cnt_o(acnt), .drop_cnt_o(dcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_start_o === 1'b1)  start_tally++;
    if (bus.frame_accept_o === 1'b1) acc_tally++;
    if (bus.frame_drop_o === 1'b1)   drop_tally++;
    if (bus.frame_accept_o === 1'b1 && bus.frame_drop_o === 1'b1) both_seen = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: decision of a whole frame from the filtering rules.
  function automatic void model(input logic [47:0] dst, input int len, input bit err,
                                output bit acc, output logic [1:0] reason);
    bit is_bc, hit;
    int n;
    n     = (len > 2047) ? 2047 : len;
    is_bc = (dst == 48'hFFFF_FFFF_FFFF);
    hit   = promisc || (dst == sta) || (is_bc && bc_en) || (dst[40] && !is_bc && mc_en);
    acc = 1'b0; reason = 2'd0;
    if (err)               reason = 2'd1;
    else if (n > MAX_LEN)  reason = 2'd3;
    else if (n < MIN_LEN)  reason = 2'd2;
    else if (!hit)         reason = 2'd0;
    else                   acc = 1'b1;
  endfunction

  function automatic int byte_flag(input int i);
    if (i < 6)       return 2;
    else if (i < 12) return 3;
    else if (i < 14) return 4;
    else             return 5;
  endfunction

  function automatic logic [7:0] byte_data(input int i, input logic [47:0] dst, input logic [15:0] et);
    if (i < 6)        return dst[47-8*i -: 8];
    else if (i == 12) return et[15:8];
    else if (i == 13) return et[7:0];
    else              return 8'($urandom);
  endfunction

  // Drive one cycle's worth of stream inputs; returns at the following negedge.
  task automatic drive_byte(input bit v, input logic [7:0] d, input int f, input bit inv);
    bus.rx_data_valid_i      = v;
    bus.rx_data_i            = d;
    bus.is_preamble_or_sfd_i = v && (f == 1);
    bus.is_dst_mac_i         = v && (f == 2);
    bus.is_src_mac_i         = v && (f == 3);
    bus.is_ether_type_i      = v && (f == 4);
    bus.is_payload_or_crc_i  = v && (f == 5);
    bus.invalid_frame_i      = inv;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int len,
                            input int err_at, input int cut_at, input bit gap);
    o_start = 1'b0;
    for (int i = 0; i < 8; i++) drive_byte(1'b1, (i == 7) ? 8'hD5 : 8'h55, 1, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (i == cut_at) break;
      drive_byte(1'b1, byte_data(i, dst, et), byte_flag(i), i == err_at);
      if (i == 0) o_start = bus.frame_start_o;
    end
    drive_byte(1'b0, 8'h00, 0, err_at == len);
    o_acc = bus.frame_accept_o;  o_drop = bus.frame_drop_o;
    o_reason = bus.drop_reason_o; o_len = bus.frame_len_o; o_et = bus.ether_type_o;
    o_acnt = acnt; o_dcnt = dcnt;
    o_extra = 1'b0;
    if (gap) begin
      drive_byte(1'b0, 8'h00, 0, 1'b0);
      o_extra = bus.frame_accept_o | bus.frame_drop_o;
      drive_byte(1'b0, 8'h00, 0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; acc_exp = 0; drop_exp = 0;
    repeat (3) drive_byte(1'b0, 8'h00, 0, 1'b0);
    vectors++;
    if ({bus.frame_start_o, bus.frame_accept_o, bus.frame_drop_o, bus.drop_reason_o,
         bus.ether_type_o, bus.frame_len_o} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got start=%b acc=%b drop=%b reason=%0d et=%h len=%0d, require all 0",
               bus.frame_start_o, bus.frame_accept_o, bus.frame_drop_o, bus.drop_reason_o,
               bus.ether_type_o, bus.frame_len_o);
    end
    vectors++;
    if (acnt !== '0 || dcnt !== '0) begin
      miscompares++; $display("FAIL reset_counters: got acc=%0d drop=%0d, require 0/0", acnt, dcnt);
    end
    rst = 1'b1;
    repeat (2) drive_byte(1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_unicast();
    sta = 48'h02_00_00_00_00_01; promisc = 1'b0; bc_en = 1'b0; mc_en = 1'b0;
    send_frame(48'h02_00_00_00_00_01, 16'h0800, 64, -1, -1, 1'b1);
    acc_exp++;
    vectors++;
    if (o_start !== 1'b1) begin miscompares++; $display("FAIL uc_start: got %b require 1", o_start); end
    vectors++;
    if (o_acc !== 1'b1 || o_drop !== 1'b0) begin
      miscompares++; $display("FAIL uc_decision: got acc=%b drop=%b require acc=1 drop=0", o_acc, o_drop);
    end
    vectors++;
    if (o_len !== 11'd64 || o_et !== 16'h0800) begin
      miscompares++; $display("FAIL uc_len_et: got len=%0d et=%h require 64/0800", o_len, o_et);
    end
    vectors++;
    if (o_acnt !== CNT_W'(acc_exp) || o_dcnt !== CNT_W'(drop_exp)) begin
      miscompares++; $display("FAIL uc_counters: got %0d/%0d require %0d/%0d", o_acnt, o_dcnt, acc_exp, drop_exp);
    end
    vectors++;
    if (o_extra !== 1'b0) begin miscompares++; $display("FAIL uc_pulse_width: decision still high at E+2"); end
  endtask

  typedef struct { logic [47:0] dst; bit p; bit b; bit m; bit acc; } addr_case_t;
  addr_case_t addr_tab [7] = '{
    '{48'h02_00_00_00_00_02, 1'b0, 1'b0, 1'b0, 1'b0},
    '{48'h02_00_00_00_00_02, 1'b1, 1'b0, 1'b0, 1'b1},
    '{48'hFF_FF_FF_FF_FF_FF, 1'b0, 1'b0, 1'b1, 1'b0},
    '{48'hFF_FF_FF_FF_FF_FF, 1'b0, 1'b1, 1'b0, 1'b1},
    '{48'h01_00_5E_00_00_01, 1'b0, 1'b1, 1'b0, 1'b0},
    '{48'h01_00_5E_00_00_01, 1'b0, 1'b0, 1'b1, 1'b1},
    '{48'h02_00_00_00_00_01, 1'b0, 1'b0, 1'b0, 1'b1}
  };

  task automatic test_addr_filter();
    sta = 48'h02_00_00_00_00_01;
    for (int k = 0; k < 7; k++) begin
      promisc = addr_tab[k].p; bc_en = addr_tab[k].b; mc_en = addr_tab[k].m;
      send_frame(addr_tab[k].dst, 16'h0800, 64, -1, -1, 1'b1);
      if (addr_tab[k].acc) acc_exp++; else drop_exp++;
      vectors++;
      if (o_acc !== addr_tab[k].acc || o_drop !== !addr_tab[k].acc ||
          (!addr_tab[k].acc && o_reason !== 2'd0)) begin
        miscompares++;
        $display("FAIL addr_case%0d: got acc=%b drop=%b reason=%0d require acc=%b reason=0",
                 k, o_acc, o_drop, o_reason, addr_tab[k].acc);
      end
      vectors++;
      if (o_acnt !== CNT_W'(acc_exp) || o_dcnt !== CNT_W'(drop_exp)) begin
        miscompares++;
        $display("FAIL addr_cnt%0d: got %0d/%0d require %0d/%0d", k, o_acnt, o_dcnt, acc_exp, drop_exp);
      end
    end
    promisc = 1'b0; bc_en = 1'b0; mc_en = 1'b0;
  endtask

  typedef struct { int len; int err_at; bit acc; logic [1:0] reason; } len_case_t;
  len_case_t len_tab [6] = '{
    '{60,   -1,  1'b0, 2'd2},
    '{1519, -1,  1'b0, 2'd3},
    '{1519, 700, 1'b0, 2'd1},
    '{1518, -1,  1'b1, 2'd0},
    '{64,   64,  1'b0, 2'd1},
    '{63,   -1,  1'b0, 2'd2}
  };

  task automatic test_length();
    sta = 48'h02_00_00_00_00_01;
    for (int k = 0; k < 6; k++) begin
      send_frame(sta, 16'h0800, len_tab[k].len, len_tab[k].err_at, -1, 1'b1);
      if (len_tab[k].acc) acc_exp++; else drop_exp++;
      vectors++;
      if (o_acc !== len_tab[k].acc || o_drop !== !len_tab[k].acc ||
          (!len_tab[k].acc && o_reason !== len_tab[k].reason)) begin
        miscompares++;
        $display("FAIL len_case%0d: got acc=%b drop=%b reason=%0d require acc=%b reason=%0d",
                 k, o_acc, o_drop, o_reason, len_tab[k].acc, len_tab[k].reason);
      end
      vectors++;
      if (o_len !== 11'(len_tab[k].len)) begin
        miscompares++; $display("FAIL len_value%0d: got %0d require %0d", k, o_len, len_tab[k].len);
      end
    end
  endtask

  task automatic test_abort();
    send_frame(sta, 16'h0800, 64, -1, 3, 1'b1);
    drop_exp++;
    vectors++;
    if (o_drop !== 1'b1 || o_acc !== 1'b0 || o_reason !== 2'd2 || o_len !== 11'd3) begin
      miscompares++;
      $display("FAIL abort_dst: got drop=%b acc=%b reason=%0d len=%0d require 1/0/2/3",
               o_drop, o_acc, o_reason, o_len);
    end
    vectors++;
    if (o_dcnt !== CNT_W'(drop_exp)) begin
      miscompares++; $display("FAIL abort_cnt: got %0d require %0d", o_dcnt, drop_exp);
    end
  endtask

  task automatic test_back_to_back();
    bit a_acc;
    send_frame(sta, 16'h0800, 70, -1, -1, 1'b0);
    a_acc = o_acc;
    send_frame(sta, 16'h88CC, 64, -1, -1, 1'b1);
    acc_exp += 2;
    vectors++;
    if (a_acc !== 1'b1 || o_acc !== 1'b1 || o_start !== 1'b1 || o_et !== 16'h88CC) begin
      miscompares++;
      $display("FAIL b2b: got accA=%b accB=%b startB=%b etB=%h require 1/1/1/88cc", a_acc, o_acc, o_start, o_et);
    end
    vectors++;
    if (o_acnt !== CNT_W'(acc_exp)) begin
      miscompares++; $display("FAIL b2b_cnt: got %0d require %0d", o_acnt, acc_exp);
    end
  endtask

  task automatic test_random();
    logic [47:0] dst;
    logic [15:0] et;
    int len, err_at;
    bit gap, exp_acc;
    logic [1:0] exp_reason;
    for (int n = 0; n < 40; n++) begin
      sta = {16'($urandom), 32'($urandom)}; sta[40] = 1'b0;
      promisc = ($urandom_range(0, 3) == 0);
      bc_en = 1'($urandom_range(0, 1)); mc_en = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: dst = sta;
        1: begin dst = {16'($urandom), 32'($urandom)}; dst[40] = 1'b0; end
        2: dst = 48'hFFFF_FFFF_FFFF;
        default: begin dst = {16'($urandom), 32'($urandom)}; dst[40] = 1'b1; end
      endcase
      et  = 16'($urandom);
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1510, 1525)) : int'($urandom_range(50, 110));
      err_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      gap = 1'($urandom_range(0, 1));
      model(dst, len, err_at >= 0, exp_acc, exp_reason);
      send_frame(dst, et, len, err_at, -1, gap);
      if (exp_acc) acc_exp++; else drop_exp++;
      vectors++;
      if (o_acc !== exp_acc || o_drop !== !exp_acc || (!exp_acc && o_reason !== exp_reason)) begin
        miscompares++;
        $display("FAIL rnd%0d_decision: got acc=%b drop=%b reason=%0d require acc=%b reason=%0d (len=%0d err_at=%0d dst=%h)",
                 n, o_acc, o_drop, o_reason, exp_acc, exp_reason, len, err_at, dst);
      end
      vectors++;
      if (o_len !== 11'(len) || o_et !== et || o_start !== 1'b1) begin
        miscompares++;
        $display("FAIL rnd%0d_fields: got len=%0d et=%h start=%b require %0d/%h/1", n, o_len, o_et, o_start, len, et);
      end
      vectors++;
      if (o_acnt !== CNT_W'(acc_exp) || o_dcnt !== CNT_W'(drop_exp)) begin
        miscompares++;
        $display("FAIL rnd%0d_cnt: got %0d/%0d require %0d/%0d", n, o_acnt, o_dcnt, acc_exp, drop_exp);
      end
      if (gap) begin
        vectors++;
        if (o_extra !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_pulse_width: decision still high at E+2", n); end
      end
    end
    promisc = 1'b0; bc_en = 1'b0; mc_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    sta = 48'h02_00_00_00_00_01;
    d0 = acc_tally + drop_tally;
    for (int i = 0; i < 8; i++) drive_byte(1'b1, 8'h55, 1, 1'b0);
    for (int i = 0; i < 20; i++) drive_byte(1'b1, byte_data(i, sta, 16'h0800), byte_flag(i), 1'b0);
    rst = 1'b0; acc_exp = 0; drop_exp = 0;
    repeat (3) drive_byte(1'b0, 8'h00, 0, 1'b0);
    rst = 1'b1;
    repeat (3) drive_byte(1'b0, 8'h00, 0, 1'b0);
    vectors++;
    if (acc_tally + drop_tally !== d0) begin
      miscompares++; $display("FAIL rst_mid_decisions: got %0d decisions require 0", acc_tally + drop_tally - d0);
    end
    vectors++;
    if (acnt !== '0 || dcnt !== '0) begin
      miscompares++; $display("FAIL rst_mid_counters: got %0d/%0d require 0/0", acnt, dcnt);
    end
  endtask

  task automatic test_reset_release_mid_frame();
    int s0, d0;
    sta = 48'h02_00_00_00_00_01;
    rst = 1'b0; acc_exp = 0; drop_exp = 0;
    for (int i = 0; i < 8; i++) drive_byte(1'b1, 8'h55, 1, 1'b0);
    for (int i = 0; i < 10; i++) drive_byte(1'b1, byte_data(i, sta, 16'h0800), byte_flag(i), 1'b0);
    s0 = start_tally; d0 = acc_tally + drop_tally;
    rst = 1'b1;
    for (int i = 10; i < 70; i++) drive_byte(1'b1, byte_data(i, sta, 16'h0800), byte_flag(i), 1'b0);
    drive_byte(1'b0, 8'h00, 0, 1'b0);
    send_frame(sta, 16'h86DD, 80, -1, -1, 1'b1);
    acc_exp++;
    vectors++;
    if (start_tally !== s0 + 1 || acc_tally + drop_tally !== d0 + 1) begin
      miscompares++;
      $display("FAIL rst_release: got starts=%0d decisions=%0d require 1/1", start_tally - s0, acc_tally + drop_tally - d0);
    end
    vectors++;
    if (o_acc !== 1'b1 || o_acnt !== CNT_W'(acc_exp) || o_dcnt !== '0) begin
      miscompares++;
      $display("FAIL rst_release_next: got acc=%b cnt=%0d/%0d require 1 cnt=%0d/0", o_acc, o_acnt, o_dcnt, acc_exp);
    end
  endtask

  task automatic test_exclusive();
    vectors++;
    if (both_seen !== 1'b0) begin
      miscompares++; $display("FAIL exclusive: got accept and drop high together, require never");
    end
    vectors++;
    if (acc_tally + drop_tally > start_tally) begin
      miscompares++;
      $display("FAIL one_per_start: got %0d decisions for %0d starts, require at most one each",
               acc_tally + drop_tally, start_tally);
    end
  endtask

  initial begin
    bus.rx_data_i = '0; bus.rx_data_valid_i = 1'b0; bus.is_preamble_or_sfd_i = 1'b0;
    bus.is_dst_mac_i = 1'b0; bus.is_src_mac_i = 1'b0; bus.is_ether_type_i = 1'b0;
    bus.is_payload_or_crc_i = 1'b0; bus.invalid_frame_i = 1'b0;
    test_reset();
    test_unicast();
    test_addr_filter();
    test_length();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    test_reset_release_mid_frame();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
